// File: rtl/logic_arb_pkg.sv
// Shared definitions for the two-requester logic-unit arbiter.
// Holds the op encoding, the FSM state encoding and the default widths.
// The optional grant counters are enabled with the LOGIC_ARB_STATS_EN macro.
package logic_arb_pkg;

  localparam int unsigned W_DEF     = 8;
  localparam int unsigned CNT_W_DEF = 8;

  localparam logic OP_XOR = 1'b0;
  localparam logic OP_AND = 1'b1;

  // 2'd3 is unused; the FSM recovers from it to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/logic_arb_if.sv
// Request/response bundle between the requesters, the arbiter and the consumer.
// Ports: req_valid/req_ready per requester, operands and op per requester,
//        rsp_valid/rsp_ready handshake with rsp_data and rsp_id.
// slave  = arbiter side, master = requester/consumer side.
interface logic_arb_if
  import logic_arb_pkg::*;
#(
  parameter int unsigned W = W_DEF
) ();

  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req_a0;
  logic [W-1:0] req_b0;
  logic         req_op0;
  logic [W-1:0] req_a1;
  logic [W-1:0] req_b1;
  logic         req_op1;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_id;

  modport slave (
    input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic, purely combinational.
// Ports: req[1:0] requests, last_grant index of previous winner,
//        enable gates all grants, gnt[1:0] one-hot or zero.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] gnt
);

  // On a tie the requester that did not win last time goes first;
  // a lone requester is always granted.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req == 2'b11) begin
        gnt = last_grant ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one registered XOR/AND unit between two requesters with
// round-robin arbitration and one transaction in flight.
// Ports: clk, rst (synchronous, active high), bus (logic_arb_if.slave),
//        grant_cnt0/grant_cnt1 saturating accept counters when
//        LOGIC_ARB_STATS_EN is defined.
// req_ready is combinational from req_valid while idle; all other outputs are registered.
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter int unsigned W = W_DEF
`ifdef LOGIC_ARB_STATS_EN
  ,
  parameter int unsigned CNT_W = CNT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  logic_arb_if.slave       bus
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         op_q, op_d;
  logic         id_q, id_d;
  logic [W-1:0] data_q, data_d;
  logic         rsp_id_q, rsp_id_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;
  logic [1:0]   gnt;
  logic         arb_en;
  logic         win;

  // Grants only in IDLE and never while reset is asserted
  assign arb_en = (state_q == IDLE) && !rst;

  rr_arb2 u_rr_arb2 (
    .req        (bus.req_valid),
    .last_grant (last_q),
    .enable     (arb_en),
    .gnt        (gnt)
  );

  assign win           = gnt[1];
  assign bus.req_ready = gnt;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = rsp_id_q;

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    id_d     = id_q;
    data_d   = data_q;
    rsp_id_d = rsp_id_q;
    valid_d  = valid_q;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          a_d     = win ? bus.req_a1  : bus.req_a0;
          b_d     = win ? bus.req_b1  : bus.req_b0;
          op_d    = win ? bus.req_op1 : bus.req_op0;
          id_d    = win;
          last_d  = win;
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (op_q)
          OP_XOR:  data_d = a_q ^ b_q;
          OP_AND:  data_d = a_q & b_q;
          default: data_d = a_q ^ b_q;
        endcase
        rsp_id_d = id_q;
        valid_d  = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_XOR;
      id_q     <= 1'b0;
      data_q   <= '0;
      rsp_id_q <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      id_q     <= id_d;
      data_q   <= data_d;
      rsp_id_q <= rsp_id_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

`ifdef LOGIC_ARB_STATS_EN
  // Saturating per-requester accept counters
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (gnt[0] && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (gnt[1] && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
// Counter checks are included when LOGIC_ARB_STATS_EN is defined.
module tb_logic_unit_arbiter;
  import logic_arb_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic_arb_if #(.W(W)) bus ();

`ifdef LOGIC_ARB_STATS_EN
  localparam int unsigned CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  logic [CNT_W-1:0] grant_cnt0;
  logic [CNT_W-1:0] grant_cnt1;
  int exp_cnt0 = 0;
  int exp_cnt1 = 0;
`endif

  int checks = 0;
  int errors = 0;
  int m_last = 1;

  logic_unit_arbiter #(
    .W(W)
`ifdef LOGIC_ARB_STATS_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef LOGIC_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Winner by the arbitration rules; -1 when nobody requests
  function automatic int pick(input logic [1:0] v, input int last);
    if (v == 2'b11) return 1 - last;
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return -1;
  endfunction

  function automatic logic [W-1:0] calc(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) r[i] = (op == OP_AND) ? (a[i] && b[i]) : (a[i] != b[i]);
    return r;
  endfunction

  task automatic model_reset();
    m_last = 1;
`ifdef LOGIC_ARB_STATS_EN
    exp_cnt0 = 0;
    exp_cnt1 = 0;
`endif
  endtask

  // One request cycle from IDLE through the response handshake.
  // Starts and ends at a falling edge with the DUT idle.
  task automatic txn(input logic [1:0] v,
                     input logic [W-1:0] a0, input logic [W-1:0] b0, input logic op0,
                     input logic [W-1:0] a1, input logic [W-1:0] b1, input logic op1,
                     input int stall);
    int           win;
    logic [W-1:0] exp;
    logic [1:0]   exp_rdy;
    win = pick(v, m_last);
    exp_rdy = (win < 0) ? 2'b00 : ((win == 0) ? 2'b01 : 2'b10);
    bus.req_valid = v;
    bus.req_a0 = a0; bus.req_b0 = b0; bus.req_op0 = op0;
    bus.req_a1 = a1; bus.req_b1 = b1; bus.req_op1 = op1;
    bus.rsp_ready = 1'($urandom);
    #1;
    checks++;
    if (bus.req_ready !== exp_rdy) begin
      errors++;
      $display("FAIL grant: req_ready=%b expected %b (valid=%b)", bus.req_ready, exp_rdy, v);
    end
    @(posedge clk);
    @(negedge clk);
    if (win < 0) begin
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_rsp: rsp_valid=%b expected 0", bus.rsp_valid);
      end
      return;
    end
    m_last = win;
    exp = (win == 1) ? calc(op1, a1, b1) : calc(op0, a0, b0);
`ifdef LOGIC_ARB_STATS_EN
    if (win == 0 && exp_cnt0 < CNT_MAX) exp_cnt0++;
    if (win == 1 && exp_cnt1 < CNT_MAX) exp_cnt1++;
    checks++;
    if (int'(grant_cnt0) != exp_cnt0 || int'(grant_cnt1) != exp_cnt1) begin
      errors++;
      $display("FAIL counters: cnt0=%0d cnt1=%0d expected %0d %0d", grant_cnt0, grant_cnt1, exp_cnt0, exp_cnt1);
    end
`endif
    // EXEC: operands change and requests may drop; none of it may matter
    bus.req_valid = 2'($urandom);
    bus.req_a0 = W'($urandom); bus.req_b0 = W'($urandom); bus.req_op0 = 1'($urandom);
    bus.req_a1 = W'($urandom); bus.req_b1 = W'($urandom); bus.req_op1 = 1'($urandom);
    bus.rsp_ready = 1'($urandom);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL exec: rsp_valid=%b req_ready=%b expected 0 00", bus.rsp_valid, bus.req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = v;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp || bus.rsp_id !== 1'(win) || bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL resp: valid=%b data=%h id=%b ready=%b expected 1 %h %0d 00",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready, exp, win);
    end
    for (int k = 0; k < stall; k++) begin
      bus.rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp || bus.rsp_id !== 1'(win) || bus.req_ready !== 2'b00) begin
        errors++;
        $display("FAIL stall: valid=%b data=%h id=%b ready=%b expected 1 %h %0d 00",
                 bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready, exp, win);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: rsp_valid=%b expected 0", bus.rsp_valid);
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 || bus.rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b data=%h id=%b expected 00 0 00 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    rst = 1'b0;
    bus.req_valid = 2'b00;
    model_reset();
  endtask

  task automatic test_single_xor();
    txn(2'b01, 8'hF0, 8'h3C, OP_XOR, 8'h00, 8'h00, OP_XOR, 0);
  endtask

  task automatic test_alternation();
    test_reset();
    for (int i = 0; i < 4; i++) txn(2'b11, 8'hAA, 8'h0F, OP_AND, 8'hFF, 8'h01, OP_XOR, 0);
  endtask

  task automatic test_backpressure();
    txn(2'b10, 8'h5A, 8'hC3, OP_AND, 8'h96, 8'h3C, OP_AND, 5);
  endtask

  task automatic test_reset_mid();
    txn(2'b01, 8'h12, 8'h34, OP_XOR, 8'h00, 8'h00, OP_XOR, 0);
    bus.req_valid = 2'b01;
    bus.req_a0 = 8'h55; bus.req_b0 = 8'h00; bus.req_op0 = OP_XOR;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h55) begin
      errors++;
      $display("FAIL pre_reset: valid=%b data=%h expected 1 55", bus.rsp_valid, bus.rsp_data);
    end
    rst = 1'b1;
    bus.req_valid = 2'b11;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 || bus.rsp_id !== 1'b0 || bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: valid=%b data=%h id=%b ready=%b expected 0 00 0 00",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready);
    end
    rst = 1'b0;
    model_reset();
    txn(2'b11, 8'h0F, 8'hF0, OP_XOR, 8'h33, 8'h33, OP_AND, 0);
  endtask

  task automatic test_lone_requester();
    for (int i = 0; i < 3; i++) txn(2'b10, 8'h00, 8'h00, OP_XOR, W'($urandom), W'($urandom), 1'($urandom), 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      txn(2'($urandom), W'($urandom), W'($urandom), 1'($urandom),
          W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

`ifdef LOGIC_ARB_STATS_EN
  task automatic test_stats();
    int exp_seq [5] = '{1, 2, 3, 3, 3};
    test_reset();
    for (int i = 0; i < 5; i++) begin
      txn(2'b01, W'($urandom), W'($urandom), OP_AND, 8'h00, 8'h00, OP_XOR, 0);
      checks++;
      if (int'(grant_cnt0) != exp_seq[i] || grant_cnt1 !== '0) begin
        errors++;
        $display("FAIL stats_seq: cnt0=%0d cnt1=%0d expected %0d 0", grant_cnt0, grant_cnt1, exp_seq[i]);
      end
    end
  endtask
`endif

  initial begin
    bus.req_valid = 2'b00;
    bus.req_a0 = '0; bus.req_b0 = '0; bus.req_op0 = OP_XOR;
    bus.req_a1 = '0; bus.req_b1 = '0; bus.req_op1 = OP_XOR;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single_xor();
    test_alternation();
    test_backpressure();
    test_reset_mid();
    test_lone_requester();
    test_random();
`ifdef LOGIC_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
